// File: rtl/edge_debounce_pkg.sv
// Shared debounce constants: default synchronizer/debounce depths and the
// 2-bit debounce state encoding used by edge_debounce.
package spi_router_pkg;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

  typedef logic [1:0] db_state_t;

  localparam db_state_t IDLE_LOW  = 2'd0;
  localparam db_state_t WAIT_HIGH = 2'd1;
  localparam db_state_t IDLE_HIGH = 2'd2;
  localparam db_state_t WAIT_LOW  = 2'd3;

  // Debounced level implied by a state: high once a rising edge is accepted.
  function automatic logic level_of(input db_state_t s);
    return (s == IDLE_HIGH) || (s == WAIT_LOW);
  endfunction

endpackage

// File: rtl/edge_debounce_sync_ff.sv
// sync_ff: N-stage flop chain bringing an asynchronous line into the clock
// domain; all stages reset asynchronously to 0.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/edge_debounce.sv
// edge_debounce: synchronizes and debounces raw_in, emitting one-cycle pos/neg
// pulses on accepted edges plus the registered debounced level.
// Optional glitch_cnt port: define EDGE_DEBOUNCE_GLITCH_CNT_EN.
module edge_debounce
  import spi_router_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_in,
  output logic       pos,
  output logic       neg,
`ifdef EDGE_DEBOUNCE_GLITCH_CNT_EN
  output logic       stable,
  output logic [7:0] glitch_cnt
`else
  output logic       stable
`endif
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pos_d, neg_d;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (raw_in),
    .q     (sync_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (sync_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          pos_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!sync_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          neg_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // stable is registered from the next state so it rises with the pos pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      pos     <= 1'b0;
      neg     <= 1'b0;
      stable  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos     <= pos_d;
      neg     <= neg_d;
      stable  <= level_of(state_d);
    end
  end

`ifdef EDGE_DEBOUNCE_GLITCH_CNT_EN
  logic       abort;
  logic [7:0] glitch_q;

  assign abort = ((state_q == WAIT_HIGH) && !sync_q) ||
                 ((state_q == WAIT_LOW)  &&  sync_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      glitch_q <= '0;
    end else if (abort && (glitch_q != 8'hFF)) begin
      glitch_q <= glitch_q + 8'd1;
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_edge_debounce.sv
// Directed bench for edge_debounce at SYNC_STAGES=2, DEBOUNCE_CYCLES=4;
// edge numbers count rising clock edges after reset release.
module tb_edge_debounce;

  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic raw_in = 1'b0;
  logic pos, neg, stable;
`ifdef EDGE_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned edge_n      = 0;
  int unsigned pulses      = 0;

  edge_debounce #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .raw_in     (raw_in),
    .pos        (pos),
    .neg        (neg),
`ifdef EDGE_DEBOUNCE_GLITCH_CNT_EN
    .stable     (stable),
    .glitch_cnt (glitch_cnt)
`else
    .stable     (stable)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic epos, input logic eneg, input logic estable);
    chk($sformatf("%s e%0d pos", tag, edge_n), {7'd0, pos}, {7'd0, epos});
    chk($sformatf("%s e%0d neg", tag, edge_n), {7'd0, neg}, {7'd0, eneg});
    chk($sformatf("%s e%0d stable", tag, edge_n), {7'd0, stable}, {7'd0, estable});
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
    edge_n++;
  endtask

  task automatic do_reset;
    reset  = 1'b1;
    raw_in = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    reset  = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_out("rst", 1'b0, 1'b0, 1'b0);
`ifdef EDGE_DEBOUNCE_GLITCH_CNT_EN
    chk("rst glitch", glitch_cnt, 8'h00);
`endif

    // 1: raw_in held high from edge 1 -> pos at edge 7 only
    raw_in = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk_out("t1", edge_n == 7, 1'b0, edge_n >= 7);
    end

    // 2: high for exactly 4 cycles is filtered
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      raw_in = (e <= 4);
      tick();
      chk_out("t2", 1'b0, 1'b0, 1'b0);
`ifdef EDGE_DEBOUNCE_GLITCH_CNT_EN
      if (edge_n == 6 || edge_n == 7)
        chk($sformatf("t2 e%0d glitch", edge_n), glitch_cnt, (edge_n == 7) ? 8'h01 : 8'h00);
`endif
    end

    // 3: high 5 cycles then low -> pos at 7, neg at 12
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      raw_in = (e <= 5);
      tick();
      chk_out("t3", edge_n == 7, edge_n == 12, (edge_n >= 7) && (edge_n < 12));
    end

    // 4: bounce 1,0,1,0 then hold 1 -> pos at edge 11, two glitches
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      raw_in = (e >= 5) || (e == 1) || (e == 3);
      tick();
      chk_out("t4", edge_n == 11, 1'b0, edge_n >= 11);
    end
`ifdef EDGE_DEBOUNCE_GLITCH_CNT_EN
    chk("t4 glitch", glitch_cnt, 8'h02);
`endif

    // 5: reset asserted mid-debounce, released with raw_in high
    do_reset();
    raw_in = 1'b1;
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    chk_out("t5 async", 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #3;
    reset  = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk_out("t5", edge_n == 7, 1'b0, edge_n >= 7);
    end

    // 6: 300 single-cycle glitches -> no pulses, counter saturates
    do_reset();
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      raw_in = 1'b1;
      tick();
      if (pos || neg || stable) pulses++;
      raw_in = 1'b0;
      tick();
      if (pos || neg || stable) pulses++;
    end
    repeat (4) tick();
    chk("t6 pulses", pulses[7:0], 8'h00);
    chk_out("t6 end", 1'b0, 1'b0, 1'b0);
`ifdef EDGE_DEBOUNCE_GLITCH_CNT_EN
    chk("t6 glitch", glitch_cnt, 8'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
